// File: rtl/mc_datapath_pkg.sv
// Shared definitions for the multi-cycle datapath: opcodes, FSM states, ALU selects.
// Used by mc_alu and mc_datapath.
package mc_datapath_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_EQ  = 3'd4
  } alu_op_e;

  function automatic logic is_legal(input logic [3:0] op);
    return (op <= OP_BEQ) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational DATA_W-wide ALU shared by all instruction classes.
// Results wrap modulo 2^DATA_W; EQ yields the compare bit zero-extended.
module mc_alu
  import mc_datapath_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        op_i,
  output logic [DATA_W-1:0] y_o,
  output logic              eq_o
);

  assign eq_o = (a_i == b_i);

  always_comb begin
    y_o = a_i + b_i;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_EQ:  y_o = {{(DATA_W-1){1'b0}}, eq_o};
      default: y_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle 16-bit-instruction CPU core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing.
// Optional `MC_DATAPATH_PERF_EN adds saturating cycle_cnt/instr_cnt outputs.
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              Reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic [PC_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              halted,
  output logic              illegal,
  output logic [PC_W-1:0]   pc
`ifdef MC_DATAPATH_PERF_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instr_cnt
`endif
);

  state_e state_q, state_d;
  logic [PC_W-1:0]   pc_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q;
  logic              illegal_q;
  logic [DATA_W-1:0] regs_q [16];

  logic [3:0]        op, rd, rs, rt;
  logic signed [3:0] imm4;
  logic [DATA_W-1:0] imm_ext;
  logic [PC_W-1:0]   imm_pc;
  logic [DATA_W-1:0] rs_val, rt_val, rd_val;
  logic [DATA_W-1:0] alu_b, alu_y;
  logic              alu_eq;
  alu_op_e           alu_sel;

  assign op      = ir_q[15:12];
  assign rd      = ir_q[11:8];
  assign rs      = ir_q[7:4];
  assign rt      = ir_q[3:0];
  assign imm4    = ir_q[3:0];
  assign imm_ext = DATA_W'(imm4);
  assign imm_pc  = PC_W'(imm4);

  // R0 is hardwired to zero on read; writes to it are dropped in WB.
  assign rs_val = (rs == 4'd0) ? '0 : regs_q[rs];
  assign rt_val = (rt == 4'd0) ? '0 : regs_q[rt];
  assign rd_val = (rd == 4'd0) ? '0 : regs_q[rd];

  always_comb begin
    alu_sel = ALU_ADD;
    case (op)
      OP_SUB:  alu_sel = ALU_SUB;
      OP_AND:  alu_sel = ALU_AND;
      OP_OR:   alu_sel = ALU_OR;
      OP_BEQ:  alu_sel = ALU_EQ;
      default: alu_sel = ALU_ADD;
    endcase
  end

  assign alu_b = ((op <= OP_OR) || (op == OP_BEQ)) ? b_q : imm_ext;

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i  (a_q),
    .b_i  (alu_b),
    .op_i (alu_sel),
    .y_o  (alu_y),
    .eq_o (alu_eq)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state_d = ST_WB;
          OP_LW, OP_SW:                           state_d = ST_MEM;
          OP_HALT:                                state_d = ST_HALT;
          default:                                state_d = ST_FETCH;
        endcase
      end
      ST_MEM:  state_d = (op == OP_LW) ? ST_WB : ST_FETCH;
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          ir_q <= imem_data;
          pc_q <= pc_q + PC_W'(1);
        end
        ST_DECODE: begin
          a_q <= rs_val;
          // SW stores rd and BEQ compares rd against rs, so both read rd into B.
          b_q <= ((op == OP_SW) || (op == OP_BEQ)) ? rd_val : rt_val;
        end
        ST_EXEC: begin
          alu_q <= alu_y;
          if ((op == OP_BEQ) && alu_eq) pc_q <= pc_q + imm_pc;
          if (!is_legal(op)) illegal_q <= 1'b1;
        end
        ST_MEM: begin
          if (op == OP_LW) mdr_q <= dmem_rdata;
        end
        ST_WB: begin
          if (rd != 4'd0) regs_q[rd] <= (op == OP_LW) ? mdr_q : alu_q;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign dmem_addr  = PC_W'(alu_q);
  assign dmem_wdata = b_q;
  assign dmem_we    = (state_q == ST_MEM) && (op == OP_SW);
  assign halted     = (state_q == ST_HALT);
  assign illegal    = illegal_q;

`ifdef MC_DATAPATH_PERF_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;
  logic        instr_done;

  assign instr_done = (state_d == ST_FETCH) &&
                      ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB));

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if ((state_q != ST_HALT) && (cycle_cnt_q != '1)) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (instr_done && (instr_cnt_q != '1))           instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: directed programs plus random programs
// compared against an instruction-level reference interpreter.
module tb_mc_datapath;

  localparam int DATA_W = 16;
  localparam int PC_W   = 8;
  localparam int MEMSZ  = 256;

  logic              clk = 1'b0;
  logic              Reset;
  logic [PC_W-1:0]   imem_addr, dmem_addr, pc;
  logic [15:0]       imem_data;
  logic [DATA_W-1:0] dmem_wdata, dmem_rdata;
  logic              dmem_we, halted, illegal;
`ifdef MC_DATAPATH_PERF_EN
  logic [31:0]       cycle_cnt, instr_cnt;
`endif

  logic [15:0]       imem [MEMSZ];
  logic [DATA_W-1:0] dmem [MEMSZ];

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  logic [PC_W-1:0]   we_addr_q [$];
  logic [DATA_W-1:0] we_data_q [$];

  mc_datapath #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata),
    .halted     (halted),
    .illegal    (illegal),
    .pc         (pc)
`ifdef MC_DATAPATH_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign imem_data  = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) if (dmem_we) dmem[dmem_addr] <= dmem_wdata;

  always @(negedge clk) begin
    if (dmem_we) begin
      we_cnt++;
      we_addr_q.push_back(dmem_addr);
      we_data_q.push_back(dmem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Reference interpreter: executes the program at ISA level and tallies cycle costs.
  logic [DATA_W-1:0] m_reg [16];
  logic [DATA_W-1:0] m_mem [MEMSZ];
  logic [PC_W-1:0]   m_pc;
  int                m_cycles, m_sw;
  logic              m_ill;

  task automatic model_run();
    logic [15:0]       ins;
    logic [3:0]        op, rd, rs, rt;
    logic [DATA_W-1:0] imm, ea;
    bit                done;
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    for (int i = 0; i < MEMSZ; i++) m_mem[i] = dmem[i];
    m_pc = '0; m_cycles = 0; m_sw = 0; m_ill = 1'b0; done = 0;
    for (int n = 0; n < 2000 && !done; n++) begin
      ins = imem[m_pc];
      m_pc = m_pc + 8'd1;
      op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
      imm = {{(DATA_W-4){ins[3]}}, ins[3:0]};
      ea  = m_reg[rs] + imm;
      case (op)
        4'h0: begin if (rd != 0) m_reg[rd] = m_reg[rs] + m_reg[rt]; m_cycles += 4; end
        4'h1: begin if (rd != 0) m_reg[rd] = m_reg[rs] - m_reg[rt]; m_cycles += 4; end
        4'h2: begin if (rd != 0) m_reg[rd] = m_reg[rs] & m_reg[rt]; m_cycles += 4; end
        4'h3: begin if (rd != 0) m_reg[rd] = m_reg[rs] | m_reg[rt]; m_cycles += 4; end
        4'h4: begin if (rd != 0) m_reg[rd] = ea; m_cycles += 4; end
        4'h5: begin if (rd != 0) m_reg[rd] = m_mem[ea[PC_W-1:0]]; m_cycles += 5; end
        4'h6: begin m_mem[ea[PC_W-1:0]] = m_reg[rd]; m_sw++; m_cycles += 4; end
        4'h7: begin
          if (m_reg[rd] == m_reg[rs]) m_pc = m_pc + imm[PC_W-1:0];
          m_cycles += 3;
        end
        4'hF: begin m_cycles += 3; done = 1; end
        default: begin m_ill = 1'b1; m_cycles += 3; end
      endcase
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    we_cnt = 0;
    we_addr_q.delete();
    we_data_q.delete();
    Reset = 1'b1;
  endtask

  task automatic run_to_halt(input string tag, output int cycles);
    cycles = 0;
    while (!halted && cycles < 3000) begin
      @(posedge clk); #1;
      cycles++;
    end
    check_eq({tag, "_halted"}, 32'(halted), 32'd1);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < MEMSZ; i++) imem[i] = 16'hF000;
  endtask

  // Compare the DUT end state against the interpreter after a full run from reset.
  task automatic run_and_compare(input string tag);
    int cyc, diffs;
    logic [PC_W-1:0] pc_at_halt;
    model_run();
    do_reset();
    run_to_halt(tag, cyc);
    pc_at_halt = pc;
    check_eq({tag, "_cycles"}, 32'(cyc), 32'(m_cycles));
    check_eq({tag, "_pc"}, 32'(pc), 32'(m_pc));
    check_eq({tag, "_illegal"}, 32'(illegal), 32'(m_ill));
    check_eq({tag, "_we_pulses"}, 32'(we_cnt), 32'(m_sw));
    diffs = 0;
    for (int i = 0; i < MEMSZ; i++) if (dmem[i] !== m_mem[i]) diffs++;
    check_eq({tag, "_mem_diffs"}, 32'(diffs), 32'd0);
    step(4);
    check_eq({tag, "_halt_pc_hold"}, 32'(pc), 32'(pc_at_halt));
    check_eq({tag, "_halt_hold"}, 32'(halted), 32'd1);
  endtask

  initial begin
    int cyc;
    Reset = 1'b0;
    clear_imem();
    for (int i = 0; i < MEMSZ; i++) dmem[i] = '0;

    // Reset state while Reset is held
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pc", 32'(pc), 32'd0);
    check_eq("rst_imem_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_illegal", 32'(illegal), 32'd0);
    check_eq("rst_we", 32'(dmem_we), 32'd0);

    // Test 1: ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; HALT
    clear_imem();
    imem[0] = 16'h4105; imem[1] = 16'h420D; imem[2] = 16'h0312; imem[3] = 16'hF000;
    do_reset();
    run_to_halt("t1", cyc);
    check_eq("t1_cycles", 32'(cyc), 32'd15);
    check_eq("t1_pc", 32'(pc), 32'd4);
`ifdef MC_DATAPATH_PERF_EN
    check_eq("t1_instr_cnt", instr_cnt, 32'd3);
    check_eq("t1_cycle_cnt", cycle_cnt, 32'd15);
`endif

    // Test 2: store then load back, forward the loaded value to a second store
    clear_imem();
    imem[0] = 16'h4105; imem[1] = 16'h6100; imem[2] = 16'h5400; imem[3] = 16'h6401;
    dmem[0] = 16'h1234; dmem[1] = 16'h5678;
    run_and_compare("t2");
    check_eq("t2_we_cnt", 32'(we_cnt), 32'd2);
    if (we_addr_q.size() >= 2) begin
      check_eq("t2_sw0_addr", 32'(we_addr_q[0]), 32'd0);
      check_eq("t2_sw0_data", 32'(we_data_q[0]), 32'd5);
      check_eq("t2_sw1_addr", 32'(we_addr_q[1]), 32'd1);
    end
    check_eq("t2_r4_stored", 32'(dmem[1]), 32'd5);

    // Test 3: BEQ at addr 2 taken back to 1 once, then falls through to 3
    clear_imem();
    imem[0] = 16'h4101; imem[1] = 16'h4221; imem[2] = 16'h721E; imem[3] = 16'h6200;
    dmem[0] = '0;
    do_reset();
    step(11);
    check_eq("t3_taken_pc", 32'(pc), 32'd1);
    step(7);
    check_eq("t3_not_taken_pc", 32'(pc), 32'd3);
    run_to_halt("t3", cyc);
    check_eq("t3_cycles", 32'(cyc + 18), 32'd25);
    check_eq("t3_r2_stored", 32'(dmem[0]), 32'd2);

    // Test 4: undefined opcode at 0 acts as NOP and sets sticky illegal
    clear_imem();
    imem[0] = 16'h9123; imem[1] = 16'h4107; imem[2] = 16'h6100;
    dmem[0] = 16'hBEEF;
    do_reset();
    step(3);
    check_eq("t4_illegal", 32'(illegal), 32'd1);
    check_eq("t4_pc", 32'(pc), 32'd1);
    check_eq("t4_no_we", 32'(we_cnt), 32'd0);
    run_to_halt("t4", cyc);
    check_eq("t4_illegal_sticky", 32'(illegal), 32'd1);
    check_eq("t4_store", 32'(dmem[0]), 32'd7);

    // Test 5: Reset dropped during the MEM cycle of SW aborts the write
    clear_imem();
    imem[0] = 16'h4105; imem[1] = 16'h420D; imem[2] = 16'h0312; imem[3] = 16'h6300;
    dmem[0] = 16'hAAAA;
    do_reset();
    step(15);
    check_eq("t5_we_in_mem", 32'(dmem_we), 32'd1);
    check_eq("t5_mem_addr", 32'(dmem_addr), 32'd0);
    check_eq("t5_mem_wdata", 32'(dmem_wdata), 32'd2);
    #2 Reset = 1'b0;
    #1;
    check_eq("t5_we_async", 32'(dmem_we), 32'd0);
    check_eq("t5_pc_async", 32'(pc), 32'd0);
    @(posedge clk); #1;
    check_eq("t5_no_write", 32'(dmem[0]), 32'hAAAA);
    run_and_compare("t5_rerun");
    check_eq("t5_result", 32'(dmem[0]), 32'd2);

    // PC wrap: every word is an illegal NOP, so each instruction costs 3 cycles
    for (int i = 0; i < MEMSZ; i++) imem[i] = 16'h8000;
    do_reset();
    step(3 * MEMSZ);
    check_eq("wrap_pc0", 32'(pc), 32'd0);
    step(3);
    check_eq("wrap_pc1", 32'(pc), 32'd1);

    // Random programs: 12-instruction body, then store r1..r15 and HALT
    for (int t = 0; t < 24; t++) begin
      logic [3:0] op, rd, rs, lo;
      int sel;
      clear_imem();
      for (int i = 0; i < 12; i++) begin
        sel = $urandom_range(0, 10);
        if (sel <= 7)       op = 4'(sel);
        else if (sel == 8)  op = 4'($urandom_range(8, 14));
        else                op = 4'h4;
        rd = 4'($urandom_range(0, 15));
        rs = 4'($urandom_range(0, 15));
        lo = (op == 4'h7) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        imem[i] = {op, rd, rs, lo};
      end
      for (int r = 1; r < 16; r++) imem[11 + r] = {4'h6, 4'(r), 4'h0, 4'(r)};
      imem[27] = 16'hF000;
      for (int i = 0; i < MEMSZ; i++) dmem[i] = 16'($urandom);
      run_and_compare($sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
